// File: rtl/uart_echo_buf.sv
// uart_echo_buf
// Buffered echo stage between the uart_core receiver (data_out) and the
// transmitter (data_in). Every received character goes through an ASCII case
// transform and is queued in a first-word fall-through FIFO. The transmitter
// drains the FIFO at its own pace, so host bursts are absorbed, not dropped.
//
// Optional build macro: UART_ECHO_LINE_MODE_EN
//   When defined, characters are held until a CR arrives (or the FIFO fills).
//   The whole line is then released.
//
// Parameters:
//   FIFO_DEPTH  queued characters (power of 2, >= 2)
//   CNT_W       width of the accepted-character counter
//   MATCH_CHAR  character that drives the match flag
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   rx_data/valid/ready  character stream from the receiver
//   tx_data/valid/ready  character stream to the transmitter
//   mode                 00 pass, 01 invert case, 10 force upper, 11 force lower
//   fifo_level           current occupancy (0..FIFO_DEPTH)
//   rx_count             accepted characters, wraps at 2^CNT_W
//   full_seen            sticky: rx_valid seen while full
//   match                last accepted raw character == MATCH_CHAR

module uart_echo_buf #(
  parameter int         FIFO_DEPTH = 16,
  parameter int         CNT_W      = 16,
  parameter logic [7:0] MATCH_CHAR = 8'h41
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  output logic                          rx_ready,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  input  logic [1:0]                    mode,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              rx_count,
  output logic                          full_seen,
  output logic                          match
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;

  // Case transform applied once, at push time. Only the two letter ranges
  // are touched; every other code passes unchanged in every mode.
  function automatic logic [7:0] xform(input logic [7:0] c, input logic [1:0] m);
    logic       is_up;
    logic       is_lo;
    logic [7:0] r;
    is_up = (c >= 8'h41) && (c <= 8'h5A);
    is_lo = (c >= 8'h61) && (c <= 8'h7A);
    r     = c;
    case (m)
      2'b01: begin
        if (is_up)      r = c + 8'h20;
        else if (is_lo) r = c - 8'h20;
      end
      2'b10: if (is_lo) r = c - 8'h20;
      2'b11: if (is_up) r = c + 8'h20;
      default: r = c;
    endcase
    return r;
  endfunction

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty = (wr_ptr == rd_ptr);

  // Holding rx_ready low during reset keeps the receiver from handing over a
  // character that would be lost while the FIFO is cleared.
  assign rx_ready   = rst_n & ~full;
  assign push       = rx_valid & rx_ready;
  assign pop        = tx_valid & tx_ready;
  assign tx_data    = mem[rd_ptr[AW-1:0]];
  assign fifo_level = wr_ptr - rd_ptr;

  // Storage has no reset: the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= xform(rx_data, mode);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rx_count  <= '0;
      full_seen <= 1'b0;
      match     <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        rx_count <= rx_count + 1'b1;
        match    <= (rx_data == MATCH_CHAR);
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (rx_valid && full) full_seen <= 1'b1;
    end
  end

`ifdef UART_ECHO_LINE_MODE_EN
  typedef enum logic {COLLECT, DRAIN} line_state_t;

  line_state_t state;
  logic [AW:0] level_next;
  logic        cr_push;

  // Occupancy after this edge, used to detect "becomes full" / "becomes empty".
  assign level_next = (wr_ptr + {{AW{1'b0}}, push}) - (rd_ptr + {{AW{1'b0}}, pop});
  assign cr_push    = push && (rx_data == 8'h0D);

  // A CR pushed on the cycle that empties the FIFO starts a new line that
  // still has to be sent, so DRAIN is kept in that case.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= COLLECT;
    end else begin
      case (state)
        COLLECT: if (cr_push || (level_next == FIFO_DEPTH[AW:0])) state <= DRAIN;
        DRAIN:   if ((level_next == '0) && !cr_push) state <= COLLECT;
        default: state <= COLLECT;
      endcase
    end
  end

  assign tx_valid = (state == DRAIN) && !empty;
`else
  assign tx_valid = !empty;
`endif

endmodule
